// File: rtl/uart_ctrl_host.sv
// uart_ctrl_host: host-side sequencer for the 4-bit control / tx_data / rx_data
// pin interface of the UART peripheral. Turns a valid/ready command stream into
// single-cycle ren_wen pulses, returns READ data, and models TX FIFO occupancy
// with a credit counter refilled by a byte-time drain timer.
module uart_ctrl_host #(
  parameter int unsigned TX_DEPTH   = 8,
  parameter int unsigned BIT_MARGIN = 11
) (
  input  logic       clk,
  input  logic       nReset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [7:0] cmd_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  input  logic [1:0] cfg_rate,
  input  logic       uart_cts,
  output logic [3:0] tx_credits,
  output logic [3:0] uart_control,
  output logic [7:0] uart_tx_data,
  input  logic [7:0] uart_rx_data
);

  localparam logic [3:0] CRED_MAX = 4'(TX_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ASSERT = 2'd1,
    ST_WAIT   = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    OP_NOP   = 2'd0,
    OP_WRITE = 2'd1,
    OP_READ  = 2'd2,
    OP_CLEAR = 2'd3
  } op_e;

  state_e      state_q, state_d;
  op_e         op_q, op_d;
  logic [1:0]  ren_wen_q, ren_wen_d;
  logic [1:0]  rate_q, rate_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [7:0]  rsp_data_q, rsp_data_d;
  logic [3:0]  credits_q, credits_d;
  logic [15:0] timer_q, timer_d;

  op_e         op_in;
  logic        accept;
  logic        issue;
  logic        wr_acc;
  logic        clr_acc;
  logic [15:0] rate_div;
  logic [31:0] byte_cyc;
  logic        drain_run;
  logic        tc;

  assign op_in = op_e'(cmd_op);

  // cmd_ready is decoded from registered state/credits plus the offered opcode,
  // so a WRITE with no credits stalls while other ops still pass.
  assign cmd_ready = (state_q != ST_ASSERT) &&
                     !((op_in == OP_WRITE) && (credits_q == '0));
  assign accept    = cmd_valid && cmd_ready;
  assign issue     = accept && (op_in != OP_NOP);
  assign wr_acc    = accept && (op_in == OP_WRITE);
  assign clr_acc   = accept && (op_in == OP_CLEAR);

  assign uart_control = {ren_wen_q, rate_q};
  assign uart_tx_data = tx_data_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_data     = rsp_data_q;
  assign tx_credits   = credits_q;

  // Bit-time divisor for the active rate and the resulting per-byte drain time.
  always_comb begin
    rate_div = 16'd5207;
    case (rate_q)
      2'b00: rate_div = 16'd5207;
      2'b01: rate_div = 16'd2604;
      2'b10: rate_div = 16'd1302;
      2'b11: rate_div = 16'd434;
    endcase
    byte_cyc = BIT_MARGIN * {16'd0, rate_div};
  end

  assign drain_run = (credits_q < CRED_MAX) && uart_cts;
  assign tc        = drain_run && (({16'd0, timer_q} + 32'd1) == byte_cyc);

  // Command sequencer: IDLE -> ASSERT (one-cycle ren_wen) -> WAIT -> IDLE/ASSERT.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    ren_wen_d   = 2'b00;
    tx_data_d   = tx_data_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    case (state_q)
      ST_IDLE: begin
        if (issue) state_d = ST_ASSERT;
      end
      ST_ASSERT: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // The peripheral has acted on the READ by now; capture its rx pins.
        if (op_q == OP_READ) begin
          rsp_valid_d = 1'b1;
          rsp_data_d  = uart_rx_data;
        end
        state_d = issue ? ST_ASSERT : ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    if (issue) begin
      op_d      = op_in;
      ren_wen_d = cmd_op;
      tx_data_d = (op_in == OP_WRITE) ? cmd_wdata : 8'h00;
    end
  end

  // Credit accounting, drain timer and rate latch.
  always_comb begin
    credits_d = credits_q;
    timer_d   = timer_q;
    rate_d    = rate_q;
    if (clr_acc) begin
      credits_d = CRED_MAX;
      timer_d   = '0;
    end else begin
      if (tc)             timer_d = '0;
      else if (drain_run) timer_d = timer_q + 16'd1;
      // A returned credit and a consumed credit on the same edge cancel out.
      case ({tc, wr_acc})
        2'b10:   credits_d = credits_q + 4'd1;
        2'b01:   credits_d = credits_q - 4'd1;
        default: credits_d = credits_q;
      endcase
    end
    // Rate may only change once the peripheral TX FIFO has fully drained.
    if ((state_q == ST_IDLE) && (credits_q == CRED_MAX)) rate_d = cfg_rate;
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_NOP;
      ren_wen_q   <= '0;
      rate_q      <= '0;
      tx_data_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      credits_q   <= CRED_MAX;
      timer_q     <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      ren_wen_q   <= ren_wen_d;
      rate_q      <= rate_d;
      tx_data_q   <= tx_data_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      credits_q   <= credits_d;
      timer_q     <= timer_d;
    end
  end

endmodule
